// File: rtl/control_ventana_pixeles_if.sv
// Bus bundle between the 5x5 window sequencer and its environment.
// master: upstream source / configuration side (drives start, sizes, pixel valid, buffer status).
// slave : the sequencer (drives buffer controls, mux selects, window enable and status).
interface control_ventana_pixeles_if #(
  parameter int unsigned BITS_BUFFERS  = 3,
  parameter int unsigned BITS_COLUMNAS = 10,
  parameter int unsigned BITS_FILAS    = 10
);
  logic                     iniciar;
  logic [BITS_BUFFERS-1:0]  cantidad_buffers_internos;
  logic [BITS_COLUMNAS-1:0] ancho_imagen;
  logic [BITS_FILAS-1:0]    alto_imagen;
  logic                     data_available;
  logic [3:0]               buffers_llenos;

  logic                     leer_pixel;
  logic                     reset_datos_buffers;
  logic                     reset_config_buffers;
  logic                     configurar;
  logic [BITS_COLUMNAS-1:0] configuracion;
  logic [3:0]               push_buffers;
  logic [3:0]               pop_buffers;
  logic [2:0]               sel_mux;
  logic                     habilitar_ventana;
  logic                     ventana_valida;
  logic [BITS_COLUMNAS-1:0] columna_actual;
  logic [BITS_FILAS-1:0]    fila_actual;
  logic                     ocupado;
  logic                     terminado;
  logic                     error_config;

  modport master (
    output iniciar, cantidad_buffers_internos, ancho_imagen, alto_imagen,
           data_available, buffers_llenos,
    input  leer_pixel, reset_datos_buffers, reset_config_buffers, configurar,
           configuracion, push_buffers, pop_buffers, sel_mux, habilitar_ventana,
           ventana_valida, columna_actual, fila_actual, ocupado, terminado,
           error_config
  );

  modport slave (
    input  iniciar, cantidad_buffers_internos, ancho_imagen, alto_imagen,
           data_available, buffers_llenos,
    output leer_pixel, reset_datos_buffers, reset_config_buffers, configurar,
           configuracion, push_buffers, pop_buffers, sel_mux, habilitar_ventana,
           ventana_valida, columna_actual, fila_actual, ocupado, terminado,
           error_config
  );
endinterface

// File: rtl/control_ventana_pixeles.sv
// Sequencer for the 5x5 pixel-window datapath: configures the line-buffer chain,
// accepts raw pixels, drives buffer push/pop, bypass mux selects and the window
// register enable, and flags cycles where the window holds a full in-image window.
// Ports: clk, reset (synchronous, active high), bus (slave side of the window bus).
module control_ventana_pixeles #(
  parameter int unsigned BITS_BUFFERS  = 3,
  parameter int unsigned BITS_COLUMNAS = 10,
  parameter int unsigned BITS_FILAS    = 10
) (
  input logic                      clk,
  input logic                      reset,
  control_ventana_pixeles_if.slave bus
);

  localparam int unsigned NUM_BUFFERS = 4;
  localparam int unsigned NUM_MUX     = 3;
  localparam int unsigned MAX_K       = 4;

  typedef enum logic [2:0] {
    REPOSO, CONF_RESET, CONF_CARGA, RECIBIENDO, FIN
  } estado_t;

  estado_t estado, estado_sig;

  logic [BITS_BUFFERS-1:0]  k_q;
  logic [BITS_COLUMNAS-1:0] ancho_q, col_q;
  logic [BITS_FILAS-1:0]    alto_q, fila_q;
  logic                     inicio_valido, acept, ultimo_pixel, subdesbordamiento;

  // Start parameters: 1 <= K <= 4 and the image at least one window wide/high
  always_comb begin
    inicio_valido = 1'b1;
    if (bus.cantidad_buffers_internos == '0 ||
        32'(bus.cantidad_buffers_internos) > MAX_K)
      inicio_valido = 1'b0;
    if (32'(bus.ancho_imagen) < 32'(bus.cantidad_buffers_internos) + 32'd1 ||
        32'(bus.alto_imagen)  < 32'(bus.cantidad_buffers_internos) + 32'd1)
      inicio_valido = 1'b0;
  end

  assign ultimo_pixel = (col_q == ancho_q - BITS_COLUMNAS'(1)) &&
                        (fila_q == alto_q - BITS_FILAS'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) estado <= REPOSO;
    else       estado <= estado_sig;
  end

  // Next state and combinational outputs
  always_comb begin
    estado_sig               = estado;
    acept                    = 1'b0;
    bus.leer_pixel           = 1'b0;
    bus.reset_datos_buffers  = 1'b0;
    bus.reset_config_buffers = 1'b0;
    bus.configurar           = 1'b0;
    bus.push_buffers         = '0;
    bus.pop_buffers          = '0;
    bus.sel_mux              = '0;
    bus.habilitar_ventana    = 1'b0;
    bus.ocupado              = (estado != REPOSO);
    bus.terminado            = 1'b0;

    case (estado)
      REPOSO:     if (bus.iniciar && inicio_valido) estado_sig = CONF_RESET;
      CONF_RESET: begin
        bus.reset_datos_buffers  = 1'b1;
        bus.reset_config_buffers = 1'b1;
        estado_sig               = CONF_CARGA;
      end
      CONF_CARGA: begin
        bus.configurar = 1'b1;
        estado_sig     = RECIBIENDO;
      end
      RECIBIENDO: begin
        acept = bus.data_available;
        if (acept && ultimo_pixel) estado_sig = FIN;
      end
      FIN: begin
        bus.terminado = 1'b1;
        estado_sig    = REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase

    bus.leer_pixel        = acept;
    bus.habilitar_ventana = acept;

    // Buffer i (depth K-i+1) starts filling once the rows ahead of it have passed,
    // and starts draining one row later.
    for (int i = 1; i <= int'(NUM_BUFFERS); i++) begin
      if (acept && i <= int'(k_q)) begin
        bus.push_buffers[i-1] = (int'(fila_q) >= int'(k_q) - i);
        bus.pop_buffers[i-1]  = (int'(fila_q) >= int'(k_q) - i + 1);
      end
    end

    // The input-end buffer (buffer_K) takes the direct pixel
    for (int j = 1; j <= int'(NUM_MUX); j++)
      bus.sel_mux[j-1] = (int'(k_q) == j);
  end

  assign subdesbordamiento = |(bus.pop_buffers & ~bus.buffers_llenos);
  assign bus.configuracion = ancho_q;

  // Latched configuration, position counters and registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q                <= '0;
      ancho_q            <= '0;
      alto_q             <= '0;
      col_q              <= '0;
      fila_q             <= '0;
      bus.columna_actual <= '0;
      bus.fila_actual    <= '0;
      bus.ventana_valida <= 1'b0;
      bus.error_config   <= 1'b0;
    end else begin
      bus.ventana_valida <= 1'b0;
      if (estado == REPOSO && bus.iniciar) begin
        if (inicio_valido) begin
          k_q                <= bus.cantidad_buffers_internos;
          ancho_q            <= bus.ancho_imagen;
          alto_q             <= bus.alto_imagen;
          col_q              <= '0;
          fila_q             <= '0;
          bus.columna_actual <= '0;
          bus.fila_actual    <= '0;
          bus.error_config   <= 1'b0;
        end else begin
          bus.error_config <= 1'b1;
        end
      end
      if (subdesbordamiento) bus.error_config <= 1'b1;
      if (acept) begin
        bus.columna_actual <= col_q;
        bus.fila_actual    <= fila_q;
        bus.ventana_valida <= (int'(fila_q) >= int'(k_q)) && (int'(col_q) >= int'(k_q));
        if (col_q == ancho_q - BITS_COLUMNAS'(1)) begin
          col_q <= '0;
          if (fila_q != alto_q - BITS_FILAS'(1)) fila_q <= fila_q + BITS_FILAS'(1);
        end else begin
          col_q <= col_q + BITS_COLUMNAS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_control_ventana_pixeles.sv
// Self-checking bench for control_ventana_pixeles: a driver issues image runs and
// pushes the expected per-pixel response into a queue; a monitor pops and compares
// whenever the sequencer accepts a pixel.
module tb_control_ventana_pixeles;
  localparam int unsigned BB = 3;
  localparam int unsigned BC = 10;
  localparam int unsigned BF = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_ventana_pixeles_if #(.BITS_BUFFERS(BB), .BITS_COLUMNAS(BC), .BITS_FILAS(BF)) bus ();

  control_ventana_pixeles #(.BITS_BUFFERS(BB), .BITS_COLUMNAS(BC), .BITS_FILAS(BF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] push;
    logic [3:0] pop;
    logic       win;
    int         fila;
    int         col;
  } exp_t;

  exp_t exp_q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   win_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] todas_salidas();
    return 64'({bus.leer_pixel, bus.reset_datos_buffers, bus.reset_config_buffers,
                bus.configurar, bus.configuracion, bus.push_buffers, bus.pop_buffers,
                bus.sel_mux, bus.habilitar_ventana, bus.ventana_valida,
                bus.columna_actual, bus.fila_actual, bus.ocupado, bus.terminado,
                bus.error_config});
  endfunction

  // Reference: a K-line chain where the buffer of depth d has seen d-1 earlier rows
  // before it fills and d rows before it drains; windows need K rows/cols of history.
  task automatic modelo(input int k, input int w, input int h);
    exp_t e;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        e.push = '0;
        e.pop  = '0;
        for (int i = 1; i <= k; i++) begin
          if (r >= (k - i + 1) - 1) e.push[i-1] = 1'b1;
          if (r >= (k - i + 1))     e.pop[i-1]  = 1'b1;
        end
        e.win  = (r >= k) && (c >= k);
        e.fila = r;
        e.col  = c;
        exp_q.push_back(e);
      end
  endtask

  task automatic monitor();
    exp_t e;
    bit   pend = 1'b0;
    logic vv_esp = 1'b0;
    int   f_esp = 0, c_esp = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("ventana_valida", 64'(bus.ventana_valida), 64'(vv_esp));
          chk("fila_actual", 64'(bus.fila_actual), 64'(f_esp));
          chk("columna_actual", 64'(bus.columna_actual), 64'(c_esp));
        end else begin
          chk("ventana_valida_sin_acept", 64'(bus.ventana_valida), 64'(0));
        end
        if (bus.ventana_valida) win_total++;
        pend = 1'b0;
        if (bus.leer_pixel) begin
          chk("leer_sin_dato", 64'(bus.data_available), 64'(1));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL acept_inesperada: got leer_pixel=1 expected no pending pixel");
          end else begin
            e = exp_q.pop_front();
            chk("push_buffers", 64'(bus.push_buffers), 64'(e.push));
            chk("pop_buffers", 64'(bus.pop_buffers), 64'(e.pop));
            chk("habilitar_ventana", 64'(bus.habilitar_ventana), 64'(1));
            vv_esp = e.win;
            f_esp  = e.fila;
            c_esp  = e.col;
            pend   = 1'b1;
          end
        end else begin
          chk("push_inactivo", 64'(bus.push_buffers), 64'(0));
          chk("pop_inactivo", 64'(bus.pop_buffers), 64'(0));
          chk("habilitar_inactivo", 64'(bus.habilitar_ventana), 64'(0));
        end
      end
    end
  endtask

  // Called at posedge+#1 with the DUT idle; returns at posedge+#1 in CONF_CARGA+1 setup
  task automatic arrancar(input int k, input int w, input int h);
    logic [2:0] sel_esp = '0;
    if (k < 4) sel_esp[k-1] = 1'b1;
    bus.cantidad_buffers_internos = BB'(k);
    bus.ancho_imagen   = BC'(w);
    bus.alto_imagen    = BF'(h);
    bus.data_available = 1'b0;
    bus.iniciar        = 1'b1;
    modelo(k, w, h);
    @(posedge clk); #1;
    bus.iniciar = 1'b0;
    chk("ocupado_conf_reset", 64'(bus.ocupado), 64'(1));
    chk("reset_datos", 64'(bus.reset_datos_buffers), 64'(1));
    chk("reset_config", 64'(bus.reset_config_buffers), 64'(1));
    chk("configurar_en_reset", 64'(bus.configurar), 64'(0));
    chk("error_tras_inicio", 64'(bus.error_config), 64'(0));
    @(posedge clk); #1;
    chk("configurar", 64'(bus.configurar), 64'(1));
    chk("configuracion", 64'(bus.configuracion), 64'(w));
    chk("reset_datos_fin", 64'(bus.reset_datos_buffers), 64'(0));
    chk("sel_mux", 64'(bus.sel_mux), 64'(sel_esp));
  endtask

  // modo 0: pixel every cycle; 1: alternate; 2: random valid plus noise on start inputs
  task automatic imagen(input int k, input int w, input int h, input int modo,
                        input int reset_en, input bit vaciar_fila2, input bit err_esp);
    int n_acc = 0;
    int win_base;
    bit listo = 1'b0;
    arrancar(k, w, h);
    win_base = win_total;
    for (int cyc = 0; cyc < 4000 && !listo; cyc++) begin
      if (reset_en > 0 && n_acc == reset_en) begin
        reset = 1'b1;
        bus.data_available = 1'b0;
        @(posedge clk); #1;
        chk("salidas_tras_reset", todas_salidas(), 64'(0));
        reset = 1'b0;
        return;
      end
      if (vaciar_fila2 && n_acc == 2 * w)
        chk("error_antes_fila2", 64'(bus.error_config), 64'(0));
      case (modo)
        0:       bus.data_available = 1'b1;
        1:       bus.data_available = (cyc % 2 == 1);
        default: begin
          bus.data_available = ($urandom_range(0, 3) != 0);
          bus.iniciar        = ($urandom_range(0, 7) == 0);
          bus.cantidad_buffers_internos = BB'($urandom_range(0, 7));
          bus.ancho_imagen   = BC'($urandom_range(0, 1023));
          bus.alto_imagen    = BF'($urandom_range(0, 1023));
        end
      endcase
      bus.buffers_llenos = (vaciar_fila2 && (n_acc / w) == 2) ? 4'h0 : 4'hF;
      @(negedge clk);
      if (bus.leer_pixel) n_acc++;
      if (bus.terminado) listo = 1'b1;
      @(posedge clk); #1;
    end
    bus.iniciar        = 1'b0;
    bus.data_available = 1'b0;
    bus.buffers_llenos = 4'hF;
    if (!listo) begin
      checks++;
      errors++;
      $display("FAIL timeout_terminado: got no terminado expected pulse after %0d pixels", w * h);
    end
    repeat (3) begin
      chk("terminado_unico", 64'(bus.terminado), 64'(0));
      chk("ocupado_tras_fin", 64'(bus.ocupado), 64'(0));
      @(posedge clk); #1;
    end
    chk("aceptados", 64'(n_acc), 64'(w * h));
    chk("ventanas", 64'(win_total - win_base), 64'((h - k) * (w - k)));
    chk("cola_vacia", 64'(exp_q.size()), 64'(0));
    chk("error_final", 64'(bus.error_config), 64'(err_esp));
  endtask

  task automatic inicio_invalido(input int k, input int w, input int h);
    bus.cantidad_buffers_internos = BB'(k);
    bus.ancho_imagen = BC'(w);
    bus.alto_imagen  = BF'(h);
    bus.iniciar      = 1'b1;
    @(posedge clk); #1;
    bus.iniciar = 1'b0;
    chk("error_invalido", 64'(bus.error_config), 64'(1));
    chk("ocupado_invalido", 64'(bus.ocupado), 64'(0));
    chk("configurar_invalido", 64'(bus.configurar), 64'(0));
    @(posedge clk); #1;
    chk("ocupado_invalido_2", 64'(bus.ocupado), 64'(0));
    chk("configurar_invalido_2", 64'(bus.configurar), 64'(0));
    chk("error_pegajoso", 64'(bus.error_config), 64'(1));
  endtask

  initial begin
    int k, w, h;
    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.cantidad_buffers_internos = '0;
    bus.ancho_imagen   = '0;
    bus.alto_imagen    = '0;
    bus.data_available = 1'b0;
    bus.buffers_llenos = 4'hF;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk("salidas_en_reset", todas_salidas(), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    imagen(2, 5, 4, 0, 0, 1'b0, 1'b0);
    imagen(4, 8, 6, 0, 0, 1'b0, 1'b0);
    imagen(2, 5, 4, 1, 0, 1'b0, 1'b0);
    inicio_invalido(0, 5, 4);
    inicio_invalido(5, 8, 8);
    inicio_invalido(4, 4, 8);
    imagen(1, 3, 3, 2, 0, 1'b0, 1'b0);
    imagen(2, 5, 4, 0, 10, 1'b0, 1'b0);
    imagen(2, 5, 4, 0, 0, 1'b0, 1'b0);
    imagen(2, 5, 4, 0, 0, 1'b1, 1'b1);
    for (int n = 0; n < 8; n++) begin
      k = int'($urandom_range(1, 4));
      w = k + 1 + int'($urandom_range(0, 5));
      h = k + 1 + int'($urandom_range(0, 3));
      imagen(k, w, h, 2, 0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_ventana_pixeles.md
Name: control_ventana_pixeles

Overview:
Sequencer for the 5x5 pixel-window datapath (four chained configurable line-buffer FIFOs, bypass muxes, 25 enabled window registers).
- Configures the line-buffer length, then accepts raw pixels from the upstream source.
- Drives every push/pop, the bypass mux selects and the window-register enable.
- Flags cycles in which the window registers hold a complete in-image window, for the downstream filter.
- Window size is K+1, where K = cantidad_buffers_internos (1..4).

Parameters:
BITS_BUFFERS, 3, width of cantidad_buffers_internos
BITS_COLUMNAS, 10, width of image-width input and column counter
BITS_FILAS, 10, width of image-height input and row counter

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
iniciar  in  1  start pulse; sampled only in REPOSO
cantidad_buffers_internos  in  BITS_BUFFERS  K = active line buffers (window = K+1)
ancho_imagen  in  BITS_COLUMNAS  pixels per row; sampled on start
alto_imagen  in  BITS_FILAS  rows per image; sampled on start
data_available  in  1  upstream pixel valid this cycle
buffers_llenos  in  4  buffer_full of buffer_1..buffer_4 (bit i-1 = buffer_i)
leer_pixel  out  1  pixel accepted this cycle (acept)
reset_datos_buffers  out  1  buffer reset_data pulse
reset_config_buffers  out  1  buffer reset_config pulse
configurar  out  1  buffer configuration load strobe
configuracion  out  BITS_COLUMNAS  line length to buffers (latched ancho)
push_buffers  out  4  push for buffer_1..buffer_4
pop_buffers  out  4  pop for buffer_1..buffer_4
sel_mux  out  3  bit j-1 = mux_j selects entrada_2 (direct pixel)
habilitar_ventana  out  1  enable for all 25 window registers
ventana_valida  out  1  window registers hold a complete window
columna_actual  out  BITS_COLUMNAS  column of last accepted pixel
fila_actual  out  BITS_FILAS  row of last accepted pixel
ocupado  out  1  high in any state except REPOSO
terminado  out  1  one-cycle pulse at end of image
error_config  out  1  sticky; cleared on the next accepted start or reset

Behaviour:
- Reset: state REPOSO. All outputs and counters 0, including configuracion, error_config, fila/columna.
- States and transitions:
  - REPOSO -> CONF_RESET on iniciar=1.
  - Start is rejected if K=0, K>4, ancho_imagen<K+1 or alto_imagen<K+1: set error_config, stay REPOSO.
  - On an accepted start, latch K, ancho and alto, clear error_config and the counters.
  - CONF_RESET (1 cycle): reset_datos_buffers=1, reset_config_buffers=1.
  - CONF_CARGA (1 cycle): configurar=1; configuracion = latched ancho, held until the next start.
  - -> RECIBIENDO.
  - RECIBIENDO: acept = data_available (combinational). leer_pixel, push_buffers, pop_buffers and habilitar_ventana are combinational from acept and the counters, with no added latency.
  - -> FIN after accepting pixel (alto-1, ancho-1).
  - FIN (1 cycle): terminado=1 -> REPOSO.
- Counters: per acept, col increments; at ancho-1 col wraps to 0 and row increments. data_available=0 stalls everything; counters hold.
- Buffer chain: active buffers are buffer_1..buffer_K; buffer_K is the input end. Buffer_i has depth d = K-i+1.
  - push_buffers[i-1] = acept && i<=K && row >= d-1.
  - pop_buffers[i-1] = acept && i<=K && row >= d.
  - Inactive buffers: push/pop = 0.
- sel_mux[j-1] = 1 iff j == K (j = 1..3), so buffer_K is fed by the direct pixel. For K=4 all bits are 0 and buffer_4 takes the pixel.
- Underflow check: error_config is set if pop_buffers[i-1]=1 while buffers_llenos[i-1]=0; operation continues.
- habilitar_ventana = acept.
- ventana_valida: registered. Equals 1 in the cycle after an acept whose (row, col) satisfy row>=K && col>=K; otherwise 0. No windows straddle row edges.
- columna_actual / fila_actual are registered on acept (cycle after).
- Window count per image = (alto-K)*(ancho-K).
- iniciar while ocupado: ignored.
- Reset mid-operation: immediate return to REPOSO, all outputs 0. The next start re-runs CONF_RESET, so buffers are cleared.
- Widths: counters compare against latched values only; no wrap beyond ancho-1 / alto-1.

Test Plan:
1. K=2, ancho=5, alto=4, data_available=1 continuously:
   - CONF_RESET then CONF_CARGA, configuracion=5.
   - 20 accepts, exactly 6 ventana_valida cycles; first one after accepting pixel (2,2), i.e. accept #13.
   - terminado pulses once after accept #20; sel_mux=3'b010.
2. K=4, ancho=8, alto=6:
   - 8 valid windows; first one after accept #37 (row 4, col 4).
   - pop_buffers[0] first asserted at row 4; sel_mux=0.
3. Same as 1 with data_available toggled 1/0 every cycle:
   - counters, push/pop and habilitar_ventana only on high cycles.
   - 6 valid windows; total 40 data cycles.
4. Invalid starts (K=0; K=5; K=4 with ancho=4):
   - error_config=1, ocupado stays 0, no configurar pulse.
   - A following valid start clears error_config.
5. reset asserted at accept #10 of scenario 1:
   - all outputs 0 next cycle.
   - A new iniciar restarts from CONF_RESET; the full scenario-1 response repeats.
6. buffers_llenos forced to 0 during scenario 1 row 2:
   - error_config set on the first pop, stays set until the next start.
   - Window sequencing is unchanged.
